// File: rtl/buffered_ram_pkg.sv
// rtl/buffered_ram_pkg.sv - shared constants and helpers for buffered_ram and its read arbiters
package buffered_ram_pkg;

    localparam int RAM_RD_LATENCY = 2;
    localparam int NREQ_MIN       = 2;
    localparam int NREQ_MAX       = 8;

    function automatic bit nreq_legal(input int n);
        return (n >= NREQ_MIN) && (n <= NREQ_MAX);
    endfunction

    // OR-reduction encoder: exact for one-hot input, no priority chain
    function automatic logic [2:0] onehot_to_idx(input logic [NREQ_MAX-1:0] oh);
        logic [2:0] idx;
        idx = '0;
        for (int i = 0; i < NREQ_MAX; i++) begin
            if (oh[i]) begin
                idx = idx | 3'(i);
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/buffered_ram_rd_arbiter_if.sv
// rtl/buffered_ram_rd_arbiter_if.sv - write port and shared read port bundle of the arbiter
interface buffered_ram_rd_arbiter_if #(
    parameter int p_addresswidth = 4,
    parameter int p_datawidth    = 16,
    parameter int p_nreq         = 4
);
    logic                             in_wren;
    logic [p_addresswidth-1:0]        in_wraddress;
    logic [p_datawidth-1:0]           in_wrdata;
    logic [p_nreq-1:0]                in_rdreq;
    logic [p_nreq*p_addresswidth-1:0] in_rdaddress;
    logic [p_nreq-1:0]                out_rdgrant;
    logic [p_datawidth-1:0]           out_rddata;
    logic [p_nreq-1:0]                out_rdvalid;

    modport slave (
        input  in_wren, in_wraddress, in_wrdata, in_rdreq, in_rdaddress,
        output out_rdgrant, out_rddata, out_rdvalid
    );

    modport master (
        output in_wren, in_wraddress, in_wrdata, in_rdreq, in_rdaddress,
        input  out_rdgrant, out_rddata, out_rdvalid
    );
endinterface

// File: rtl/buffered_ram.sv
// rtl/buffered_ram.sv - simple dual-port RAM, fixed registered read latency, read-old on collision
module buffered_ram
    import buffered_ram_pkg::*;
#(
    parameter int    p_addresswidth = 4,
    parameter int    p_datawidth    = 16,
    parameter string p_init_file    = "UNUSED"
) (
    input  logic                      clk,
    input  logic                      wren,
    input  logic [p_addresswidth-1:0] wraddress,
    input  logic [p_datawidth-1:0]    wrdata,
    input  logic [p_addresswidth-1:0] rdaddress,
    output logic [p_datawidth-1:0]    q
);
    logic [p_datawidth-1:0] mem_q [2**p_addresswidth];
    logic [p_datawidth-1:0] rd_q  [RAM_RD_LATENCY];

    always_ff @(posedge clk) begin
        if (wren) begin
            mem_q[wraddress] <= wrdata;
        end
        rd_q[0] <= mem_q[rdaddress];
        for (int s = 1; s < RAM_RD_LATENCY; s++) begin
            rd_q[s] <= rd_q[s-1];
        end
    end

    assign q = rd_q[RAM_RD_LATENCY-1];

endmodule

// File: rtl/rr_grant.sv
// rtl/rr_grant.sv - combinational round-robin search starting after the last granted index
module rr_grant #(
    parameter  int p_n = 4,
    localparam int IW  = $clog2(p_n)
) (
    input  logic [p_n-1:0] req_i,
    input  logic [IW-1:0]  last_i,
    output logic [p_n-1:0] grant_o,
    output logic [IW-1:0]  next_o
);
    always_comb begin : rr_search
        logic [IW:0]   sum;
        logic [IW-1:0] idx;
        logic          found;
        grant_o = '0;
        next_o  = last_i;
        found   = 1'b0;
        sum     = '0;
        idx     = '0;
        for (int off = 1; off <= p_n; off++) begin
            sum = {1'b0, last_i} + (IW+1)'(off);
            if (sum >= (IW+1)'(p_n)) begin
                sum = sum - (IW+1)'(p_n);
            end
            idx = sum[IW-1:0];
            if (!found && req_i[idx]) begin
                found        = 1'b1;
                grant_o[idx] = 1'b1;
                next_o       = idx;
            end
        end
    end

endmodule

// File: rtl/buffered_ram_rd_arbiter.sv
// rtl/buffered_ram_rd_arbiter.sv - round-robin sharing of buffered_ram read port among p_nreq requesters
// Optional write-to-read forwarding on same-cycle address collision: BUFFERED_RAM_ARB_WRFWD_EN
module buffered_ram_rd_arbiter
    import buffered_ram_pkg::*;
#(
    parameter int    p_addresswidth = 4,
    parameter int    p_datawidth    = 16,
    parameter int    p_nreq         = 4,
    parameter string p_init_file    = "UNUSED"
) (
    input  logic                    inclk,
    input  logic                    inrst,
    buffered_ram_rd_arbiter_if.slave bus
);
    localparam int IW = $clog2(p_nreq);

    if (!nreq_legal(p_nreq)) begin : g_nreq_range
        $error("buffered_ram_rd_arbiter: p_nreq out of range 2..8");
    end

    logic [IW-1:0]             last_q;
    logic [IW-1:0]             last_d;
    logic [p_nreq-1:0]         rr_gnt;
    logic [p_nreq-1:0]         gnt;
    logic [IW-1:0]             gnt_idx;
    logic [p_addresswidth-1:0] rd_addr_d;
    logic [p_addresswidth-1:0] rd_addr_q;
    logic [p_addresswidth-1:0] ram_rdaddr;
    logic [p_datawidth-1:0]    ram_q;
    logic [p_nreq-1:0]         vld_q [RAM_RD_LATENCY];

    rr_grant #(.p_n(p_nreq)) u_rr_grant (
        .req_i   (bus.in_rdreq),
        .last_i  (last_q),
        .grant_o (rr_gnt),
        .next_o  (last_d)
    );

    assign gnt        = inrst ? '0 : rr_gnt;
    assign gnt_idx    = IW'(onehot_to_idx(NREQ_MAX'(gnt)));
    assign rd_addr_d  = bus.in_rdaddress[gnt_idx*p_addresswidth +: p_addresswidth];
    // Idle cycles re-read the last address; no valid is ever issued for them
    assign ram_rdaddr = (|gnt) ? rd_addr_d : rd_addr_q;

    always_ff @(posedge inclk or posedge inrst) begin
        if (inrst) begin
            last_q    <= IW'(p_nreq - 1);
            rd_addr_q <= '0;
            for (int s = 0; s < RAM_RD_LATENCY; s++) begin
                vld_q[s] <= '0;
            end
        end else begin
            if (|gnt) begin
                last_q    <= last_d;
                rd_addr_q <= rd_addr_d;
            end
            vld_q[0] <= gnt;
            for (int s = 1; s < RAM_RD_LATENCY; s++) begin
                vld_q[s] <= vld_q[s-1];
            end
        end
    end

    buffered_ram #(
        .p_addresswidth (p_addresswidth),
        .p_datawidth    (p_datawidth),
        .p_init_file    (p_init_file)
    ) u_ram (
        .clk       (inclk),
        .wren      (bus.in_wren),
        .wraddress (bus.in_wraddress),
        .wrdata    (bus.in_wrdata),
        .rdaddress (ram_rdaddr),
        .q         (ram_q)
    );

`ifdef BUFFERED_RAM_ARB_WRFWD_EN
    logic                   fwd_hit_d;
    logic                   fwd_hit_q  [RAM_RD_LATENCY];
    logic [p_datawidth-1:0] fwd_data_q [RAM_RD_LATENCY];

    assign fwd_hit_d = (|gnt) && bus.in_wren && (bus.in_wraddress == rd_addr_d);

    always_ff @(posedge inclk or posedge inrst) begin
        if (inrst) begin
            for (int s = 0; s < RAM_RD_LATENCY; s++) begin
                fwd_hit_q[s] <= 1'b0;
            end
        end else begin
            fwd_hit_q[0] <= fwd_hit_d;
            for (int s = 1; s < RAM_RD_LATENCY; s++) begin
                fwd_hit_q[s] <= fwd_hit_q[s-1];
            end
        end
    end

    always_ff @(posedge inclk) begin
        fwd_data_q[0] <= bus.in_wrdata;
        for (int s = 1; s < RAM_RD_LATENCY; s++) begin
            fwd_data_q[s] <= fwd_data_q[s-1];
        end
    end

    assign bus.out_rddata = fwd_hit_q[RAM_RD_LATENCY-1] ? fwd_data_q[RAM_RD_LATENCY-1] : ram_q;
`else
    assign bus.out_rddata = ram_q;
`endif

    assign bus.out_rdgrant = gnt;
    assign bus.out_rdvalid = vld_q[RAM_RD_LATENCY-1];

endmodule
